// File: rtl/adf4030_trig_pkg.sv
// Shared types and default parameters for the ADF4030 trigger scheduler.
// The channel state encoding here is also what trig_state reports.
package adf4030_trig_pkg;

    localparam int DEF_CHANNEL_COUNT = 8;
    localparam int DEF_PHASE_WIDTH   = 16;
    localparam int DEF_BURST_WIDTH   = 8;
    localparam int TS_WIDTH          = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } trig_state_e;

endpackage

// File: rtl/adf4030_trig_chan.sv
// One trigger channel: arm / BSYNC-relative delay / fire FSM with burst count and overrun flag.
// With ADF4030_TRIG_TIMESTAMP_EN defined it also captures the cycle counter on every pulse.
module adf4030_trig_chan
    import adf4030_trig_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_run,
    input  logic                   i_en,
    input  logic                   i_bsync,
    input  logic                   i_select_trig,
    input  logic                   i_manual_trig,
    input  logic [PHASE_WIDTH-1:0] i_phase,
    input  logic [BURST_WIDTH-1:0] i_burst_len,
    output logic                   o_trig,
    output logic [2:0]             o_state,
    output logic                   o_overrun,
    output logic                   o_busy
`ifdef ADF4030_TRIG_TIMESTAMP_EN
    ,
    input  logic [TS_WIDTH-1:0]    i_ts,
    output logic [TS_WIDTH-1:0]    o_timestamp
`endif
);

    localparam logic [PHASE_WIDTH-1:0] PHASE_ONE = 1;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

    trig_state_e            r_state;
    logic [PHASE_WIDTH-1:0] r_delay;
    logic [BURST_WIDTH-1:0] r_burst;
    logic                   r_overrun;
    logic [BURST_WIDTH-1:0] w_burst_inc;
    logic                   w_rearm;

    assign w_burst_inc = (r_burst == '1) ? r_burst : r_burst + BURST_ONE;
    assign w_rearm     = !i_select_trig || (i_burst_len == '0) || (w_burst_inc < i_burst_len);

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_delay   <= '0;
            r_burst   <= '0;
            r_overrun <= 1'b0;
        end else if (i_run) begin
            if (!i_en) begin
                r_state   <= ST_IDLE;
                r_delay   <= '0;
                r_burst   <= '0;
                r_overrun <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!i_select_trig || i_manual_trig) begin
                            r_state <= ST_ARMED;
                            r_burst <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (i_bsync) begin
                            r_state <= ST_DELAY;
                            r_delay <= i_phase;
                        end
                    end
                    ST_DELAY: begin
                        if (i_bsync) r_overrun <= 1'b1;
                        if (r_delay == '0) r_state <= ST_FIRE;
                        else               r_delay <= r_delay - PHASE_ONE;
                    end
                    ST_FIRE: begin
                        r_burst <= w_burst_inc;
                        r_state <= w_rearm ? ST_ARMED : ST_DONE;
                    end
                    ST_DONE: begin
                        if (i_manual_trig) begin
                            r_state <= ST_ARMED;
                            r_burst <= '0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Gating with the enable gives the abort its same-cycle pulse suppression.
    assign o_trig    = (r_state == ST_FIRE) && i_en;
    assign o_state   = r_state;
    assign o_overrun = r_overrun;
    assign o_busy    = (r_state == ST_ARMED) || (r_state == ST_DELAY) || (r_state == ST_FIRE);

`ifdef ADF4030_TRIG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_timestamp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_timestamp <= '0;
        else if (o_trig) r_timestamp <= i_ts;
    end

    assign o_timestamp = r_timestamp;
`endif

endmodule

// File: rtl/adf4030_trig_sched.sv
// ADF4030 trigger scheduler top: CHANNEL_COUNT independent trigger channels plus busy summary.
// Define ADF4030_TRIG_TIMESTAMP_EN to add the free-running cycle counter and trig_timestamp port.
module adf4030_trig_sched
    import adf4030_trig_pkg::*;
#(
    parameter int CHANNEL_COUNT = DEF_CHANNEL_COUNT,
    parameter int PHASE_WIDTH   = DEF_PHASE_WIDTH,
    parameter int BURST_WIDTH   = DEF_BURST_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    bsync,
    input  logic                                    select_trig,
    input  logic                                    manual_trig,
    input  logic [CHANNEL_COUNT-1:0]                channel_en,
    input  logic [CHANNEL_COUNT-1:0][PHASE_WIDTH-1:0] channel_phase,
    input  logic [BURST_WIDTH-1:0]                  burst_len,
    output logic [CHANNEL_COUNT-1:0]                trig_out,
    output logic [CHANNEL_COUNT-1:0][2:0]           trig_state,
    output logic [CHANNEL_COUNT-1:0]                overrun,
    output logic                                    busy
`ifdef ADF4030_TRIG_TIMESTAMP_EN
    ,
    output logic [CHANNEL_COUNT-1:0][TS_WIDTH-1:0]  trig_timestamp
`endif
);

    logic                     r_run;
    logic [CHANNEL_COUNT-1:0] w_busy;

    // Reset release is taken on the first edge; channels may move from the second edge on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

`ifdef ADF4030_TRIG_TIMESTAMP_EN
    localparam logic [TS_WIDTH-1:0] TS_ONE = 1;
    logic [TS_WIDTH-1:0] r_ts_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_ts_cnt <= '0;
        else       r_ts_cnt <= r_ts_cnt + TS_ONE;
    end
`endif

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
        adf4030_trig_chan #(
            .PHASE_WIDTH (PHASE_WIDTH),
            .BURST_WIDTH (BURST_WIDTH)
        ) u_chan (
            .clk           (clk),
            .rstn          (rstn),
            .i_run         (r_run),
            .i_en          (channel_en[g]),
            .i_bsync       (bsync),
            .i_select_trig (select_trig),
            .i_manual_trig (manual_trig),
            .i_phase       (channel_phase[g]),
            .i_burst_len   (burst_len),
            .o_trig        (trig_out[g]),
            .o_state       (trig_state[g]),
            .o_overrun     (overrun[g]),
            .o_busy        (w_busy[g])
`ifdef ADF4030_TRIG_TIMESTAMP_EN
            ,
            .i_ts          (r_ts_cnt),
            .o_timestamp   (trig_timestamp[g])
`endif
        );
    end

    assign busy = |w_busy;

endmodule

// File: tb/tb_adf4030_trig_sched.sv
// Self-checking bench for adf4030_trig_sched: directed scenarios plus random stimulus
// checked against a time-based reference model (expected fire cycle = bsync cycle + phase + 2).
module tb_adf4030_trig_sched;

    localparam int CC = 16;
    localparam int PW = 8;
    localparam int BW = 4;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_COUNT = 2;
    localparam int M_FIRE  = 3;
    localparam int M_DONE  = 4;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   bsync = 1'b0;
    logic                   select_trig = 1'b0;
    logic                   manual_trig = 1'b0;
    logic [CC-1:0]          channel_en = '0;
    logic [CC-1:0][PW-1:0]  channel_phase = '0;
    logic [BW-1:0]          burst_len = '0;
    logic [CC-1:0]          trig_out;
    logic [CC-1:0][2:0]     trig_state;
    logic [CC-1:0]          overrun;
    logic                   busy;
`ifdef ADF4030_TRIG_TIMESTAMP_EN
    logic [CC-1:0][31:0]    trig_timestamp;
`endif

    int checks = 0;
    int failures = 0;

    adf4030_trig_sched #(
        .CHANNEL_COUNT (CC),
        .PHASE_WIDTH   (PW),
        .BURST_WIDTH   (BW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bsync         (bsync),
        .select_trig   (select_trig),
        .manual_trig   (manual_trig),
        .channel_en    (channel_en),
        .channel_phase (channel_phase),
        .burst_len     (burst_len),
        .trig_out      (trig_out),
        .trig_state    (trig_state),
        .overrun       (overrun),
        .busy          (busy)
`ifdef ADF4030_TRIG_TIMESTAMP_EN
        ,
        .trig_timestamp (trig_timestamp)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: absolute cycle numbers and scheduled fire times per channel.
    int          m_mode    [CC];
    int          m_fire_at [CC];
    int          m_cnt     [CC];
    bit          m_ovr     [CC];
    logic [31:0] m_ts      [CC];
    int          m_cyc;
    bit          m_run;
    logic [31:0] m_clk;

    logic [CC-1:0]      exp_trig;
    logic [CC-1:0][2:0] exp_state;
    logic [CC-1:0]      exp_ovr;
    logic               exp_busy;

    task automatic model_reset();
        for (int i = 0; i < CC; i++) begin
            m_mode[i] = M_IDLE; m_fire_at[i] = -1; m_cnt[i] = 0; m_ovr[i] = 0; m_ts[i] = '0;
        end
        m_cyc = 0; m_run = 0; m_clk = '0;
    endtask

    task automatic model_update();
        for (int i = 0; i < CC; i++) begin
            if (!m_run) continue;
            if (!channel_en[i]) begin
                m_mode[i] = M_IDLE; m_ovr[i] = 0; m_cnt[i] = 0;
                continue;
            end
            case (m_mode[i])
                M_IDLE: if (!select_trig || manual_trig) begin m_mode[i] = M_WAIT; m_cnt[i] = 0; end
                M_WAIT: if (bsync) begin
                    m_mode[i] = M_COUNT;
                    m_fire_at[i] = m_cyc + 2 + int'(channel_phase[i]);
                end
                M_COUNT: begin
                    if (bsync) m_ovr[i] = 1;
                    if (m_cyc + 1 == m_fire_at[i]) m_mode[i] = M_FIRE;
                end
                M_FIRE: begin
                    m_ts[i] = m_clk;
                    if (m_cnt[i] < (1 << BW) - 1) m_cnt[i]++;
                    if (!select_trig || burst_len == 0 || m_cnt[i] < int'(burst_len)) m_mode[i] = M_WAIT;
                    else m_mode[i] = M_DONE;
                end
                M_DONE: if (manual_trig) begin m_mode[i] = M_WAIT; m_cnt[i] = 0; end
                default: m_mode[i] = M_IDLE;
            endcase
        end
        m_run = 1;
        m_clk = m_clk + 32'd1;
        m_cyc++;
    endtask

    task automatic refresh_exp();
        exp_busy = 1'b0;
        for (int i = 0; i < CC; i++) begin
            exp_trig[i]  = (m_mode[i] == M_FIRE) && channel_en[i];
            exp_state[i] = 3'(m_mode[i]);
            exp_ovr[i]   = m_ovr[i];
            if (m_mode[i] >= M_WAIT && m_mode[i] <= M_FIRE) exp_busy = 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        refresh_exp();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bsync = 1'b0; manual_trig = 1'b0; select_trig = 1'b0;
        channel_en = '0; channel_phase = '0; burst_len = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        channel_en = '1; bsync = 1'b1; manual_trig = 1'b1; select_trig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (trig_out !== '0) begin failures++; $display("FAIL reset_trig got=%h want=0", trig_out); end
        checks++; if (trig_state !== '0) begin failures++; $display("FAIL reset_state got=%h want=0", trig_state); end
        checks++; if (overrun !== '0) begin failures++; $display("FAIL reset_overrun got=%h want=0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        bsync = 1'b0; manual_trig = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        advance();
        settle();
        checks++; if (trig_state[0] !== 3'd0) begin failures++; $display("FAIL reset_edge1 got=%0d want=0", trig_state[0]); end
        advance();
        settle();
        checks++; if (trig_state[0] !== 3'd1) begin failures++; $display("FAIL reset_edge2 got=%0d want=1", trig_state[0]); end
        checks++; if (busy !== exp_busy) begin failures++; $display("FAIL reset_busy_after got=%b want=%b", busy, exp_busy); end
    endtask

    task automatic test_continuous();
        int pulses = 0;
        do_reset();
        channel_en = 16'h0001; channel_phase[0] = 8'd5;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bsync = ((cyc % 64) == 10);
            settle();
            checks++;
            if (trig_out !== exp_trig) begin
                failures++; $display("FAIL cont_model cyc=%0d got=%h want=%h", cyc, trig_out, exp_trig);
            end
            checks++;
            if (trig_out[0] !== ((cyc % 64) == 17)) begin
                failures++; $display("FAIL cont_timing cyc=%0d got=%b want=%b", cyc, trig_out[0], (cyc % 64) == 17);
            end
            if (trig_out[0]) pulses++;
            advance();
        end
        bsync = 1'b0;
        checks++; if (pulses != 3) begin failures++; $display("FAIL cont_count got=%0d want=3", pulses); end
    endtask

    task automatic test_burst();
        int pulses = 0;
        do_reset();
        select_trig = 1'b1; burst_len = 4'd3; channel_en = 16'h0001; channel_phase[0] = 8'd2;
        for (int cyc = 0; cyc < 180; cyc++) begin
            manual_trig = (cyc == 3) || (cyc == 100);
            bsync = ((cyc % 20) == 10);
            settle();
            checks++;
            if (trig_out !== exp_trig || trig_state !== exp_state) begin
                failures++; $display("FAIL burst_model cyc=%0d got=%h/%h want=%h/%h", cyc, trig_out, trig_state, exp_trig, exp_state);
            end
            if (trig_out[0]) pulses++;
            if (cyc == 99) begin
                checks++; if (pulses != 3) begin failures++; $display("FAIL burst_first got=%0d want=3", pulses); end
                checks++; if (trig_state[0] !== 3'd4) begin failures++; $display("FAIL burst_done1 got=%0d want=4", trig_state[0]); end
            end
            advance();
        end
        manual_trig = 1'b0; bsync = 1'b0;
        settle();
        checks++; if (pulses != 6) begin failures++; $display("FAIL burst_second got=%0d want=6", pulses); end
        checks++; if (trig_state[0] !== 3'd4) begin failures++; $display("FAIL burst_done2 got=%0d want=4", trig_state[0]); end
        advance();
    endtask

    task automatic test_overrun();
        do_reset();
        channel_en = 16'h0001; channel_phase[0] = 8'd100;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bsync = (cyc >= 5) && (((cyc - 5) % 50) == 0);
            settle();
            checks++;
            if (trig_out !== exp_trig || overrun !== exp_ovr) begin
                failures++; $display("FAIL ovr_model cyc=%0d got=%h/%h want=%h/%h", cyc, trig_out, overrun, exp_trig, exp_ovr);
            end
            advance();
        end
        bsync = 1'b0;
        settle();
        checks++; if (overrun[0] !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", overrun[0]); end
        advance();
        channel_en = '0;
        settle();
        checks++; if (trig_out[0] !== 1'b0) begin failures++; $display("FAIL ovr_abort_trig got=%b want=0", trig_out[0]); end
        advance();
        settle();
        checks++; if (overrun[0] !== 1'b0 || trig_state[0] !== 3'd0) begin
            failures++; $display("FAIL ovr_clear got=%b/%0d want=0/0", overrun[0], trig_state[0]);
        end
        advance();
    endtask

    task automatic test_abort();
        do_reset();
        channel_phase[0] = 8'd10;
        for (int cyc = 0; cyc < 40; cyc++) begin
            channel_en = (cyc < 12) ? 16'h0001 : 16'h0000;
            bsync = (cyc == 4);
            settle();
            checks++;
            if (trig_out[0] !== 1'b0 || trig_state !== exp_state) begin
                failures++; $display("FAIL abort_en cyc=%0d got=%b/%h want=0/%h", cyc, trig_out[0], trig_state, exp_state);
            end
            if (cyc == 13) begin
                checks++; if (trig_state[0] !== 3'd0) begin failures++; $display("FAIL abort_idle got=%0d want=0", trig_state[0]); end
            end
            advance();
        end
        do_reset();
        channel_en = 16'h0001; channel_phase[0] = 8'd10;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bsync = (cyc == 4);
            settle();
            if (cyc == 9) begin
                checks++; if (trig_state[0] !== 3'd2) begin failures++; $display("FAIL abort_pre got=%0d want=2", trig_state[0]); end
            end
            advance();
        end
        bsync = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (trig_out !== '0 || trig_state !== '0 || overrun !== '0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_rst got=%h/%h/%h/%b want=all zero", trig_out, trig_state, overrun, busy);
        end
        model_reset();
        @(posedge clk);
    endtask

    task automatic test_multi();
        int first [CC];
        do_reset();
        channel_en = '1;
        for (int k = 0; k < CC; k++) begin
            channel_phase[k] = PW'(k);
            first[k] = -1;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            bsync = (cyc == 5);
            settle();
            checks++;
            if (trig_out !== exp_trig) begin
                failures++; $display("FAIL multi_model cyc=%0d got=%h want=%h", cyc, trig_out, exp_trig);
            end
            for (int k = 0; k < CC; k++) if (trig_out[k] && first[k] < 0) first[k] = cyc;
            advance();
        end
        bsync = 1'b0;
        for (int k = 0; k < CC; k++) begin
            checks++;
            if (first[k] != 5 + 2 + k) begin failures++; $display("FAIL multi_lat ch=%0d got=%0d want=%0d", k, first[k], 7 + k); end
        end
`ifdef ADF4030_TRIG_TIMESTAMP_EN
        for (int k = 0; k + 1 < CC; k++) begin
            checks++;
            if (trig_timestamp[k+1] - trig_timestamp[k] !== 32'd1) begin
                failures++; $display("FAIL multi_ts ch=%0d got=%0d want=1", k, trig_timestamp[k+1] - trig_timestamp[k]);
            end
        end
`endif
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        channel_en = '1; burst_len = 4'd2;
        for (int i = 0; i < CC; i++) channel_phase[i] = PW'($urandom_range(0, 20));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bsync = ($urandom_range(0, 13) == 0);
            manual_trig = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) select_trig = ~select_trig;
            if ($urandom_range(0, 99) == 0) burst_len = BW'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) begin
                idx = int'($urandom_range(0, CC - 1));
                channel_en[idx] = ~channel_en[idx];
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, CC - 1));
                channel_phase[idx] = PW'($urandom_range(0, 24));
            end
            settle();
            checks++; if (trig_out !== exp_trig) begin failures++; $display("FAIL rnd_trig cyc=%0d got=%h want=%h", cyc, trig_out, exp_trig); end
            checks++; if (trig_state !== exp_state) begin failures++; $display("FAIL rnd_state cyc=%0d got=%h want=%h", cyc, trig_state, exp_state); end
            checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL rnd_ovr cyc=%0d got=%h want=%h", cyc, overrun, exp_ovr); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
`ifdef ADF4030_TRIG_TIMESTAMP_EN
            for (int i = 0; i < CC; i++) begin
                checks++;
                if (trig_timestamp[i] !== m_ts[i]) begin
                    failures++; $display("FAIL rnd_ts cyc=%0d ch=%0d got=%0d want=%0d", cyc, i, trig_timestamp[i], m_ts[i]);
                end
            end
`endif
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_continuous();
        test_burst();
        test_overrun();
        test_abort();
        test_multi();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
